// File: rtl/binary_to_bcd_pkg.sv
// Shared definitions for the sequential binary-to-packed-BCD converter.
// Default widths, FSM state encoding and the iteration-counter sizing helper.
package binary_to_bcd_pkg;

    localparam int BIN_W_DEF  = 32;
    localparam int DIGITS_DEF = 7;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Counter must be able to hold 0..BIN_W.
    function automatic int cnt_width(input int bin_w);
        return $clog2(bin_w + 1);
    endfunction

    localparam int CNT_W_DEF = cnt_width(BIN_W_DEF);

endpackage

// File: rtl/binary_to_bcd_digit_adjust.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets +3 so that the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adjust (
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/binary_to_bcd.sv
// Sequential binary-to-packed-BCD converter, one double-dabble shift per clock.
// start is taken only in IDLE; done pulses once when bcd is loaded with a new result.
//
//   state | meaning
//   IDLE  | waiting for start, bcd holds the last result
//   BUSY  | shifting; BIN_W iterations, then load bcd and pulse done
module binary_to_bcd
    import binary_to_bcd_pkg::*;
#(
    parameter int BIN_W  = BIN_W_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      binary_in,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  done
);

    localparam int ACC_W = 4 * DIGITS;
    localparam int CW    = cnt_width(BIN_W);
    localparam logic [CW-1:0] CNT_LAST = CW'(BIN_W - 1);

    state_t             state, state_next;
    logic [ACC_W-1:0]   acc, acc_next, acc_adj;
    logic [BIN_W-1:0]   sh, sh_next;
    logic [CW-1:0]      cnt, cnt_next;
    logic [ACC_W-1:0]   bcd_next;
    logic               done_next;

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit    (acc[4*i +: 4]),
            .adjusted (acc_adj[4*i +: 4])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            sh    <= '0;
            cnt   <= '0;
            bcd   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            sh    <= sh_next;
            cnt   <= cnt_next;
            bcd   <= bcd_next;
            done  <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        acc_next   = acc;
        sh_next    = sh;
        cnt_next   = cnt;
        bcd_next   = bcd;
        done_next  = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    sh_next    = binary_in;
                    acc_next   = '0;
                    cnt_next   = '0;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                // Carry out of the top digit is dropped: result is modulo 10^DIGITS.
                acc_next = ACC_W'({acc_adj, sh[BIN_W-1]});
                sh_next  = {sh[BIN_W-2:0], 1'b0};
                cnt_next = cnt + CW'(1);
                if (cnt == CNT_LAST) begin
                    bcd_next   = acc_next;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_binary_to_bcd.sv
// Scoreboard bench for binary_to_bcd: the driver predicts accepted requests and
// their decimal result; a negedge monitor checks every done pulse and bcd hold.
module tb_binary_to_bcd;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] binary_in = '0;
    logic [27:0] bcd;
    logic        done;

    binary_to_bcd dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .binary_in (binary_in),
        .bcd       (bcd),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [27:0] val;
        int          edge_n;
    } exp_t;

    exp_t        exp_q[$];
    int          cyc = 0;
    int          next_ok = 0;
    logic        rst_prev = 1'b1;
    logic [27:0] model_bcd = '0;
    int          checks = 0;
    int          errors = 0;

    always @(posedge clk) begin
        cyc++;
        rst_prev = rst;
    end

    function automatic logic [27:0] to_bcd(input logic [31:0] v);
        longint unsigned x;
        logic [27:0] r;
        x = longint'(v) % 64'd10000000;
        r = '0;
        for (int i = 0; i < 7; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: edge index cyc is the edge just passed.
    always @(negedge clk) begin
        exp_t e;
        if (rst_prev) begin
            exp_q.delete();
            model_bcd = '0;
            chk("reset_bcd", 32'(bcd), 32'h0);
            chk("reset_done", 32'(done), 32'h0);
        end else begin
            if (exp_q.size() > 0 && exp_q[0].edge_n < cyc) begin
                e = exp_q.pop_front();
                chk("missing_done_edge", 32'(cyc), 32'(e.edge_n));
            end
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_latency", 32'(cyc), 32'(e.edge_n));
                    chk("result_bcd", 32'(bcd), 32'(e.val));
                    model_bcd = e.val;
                end
            end else begin
                chk("hold_bcd", 32'(bcd), 32'(model_bcd));
            end
        end
    end

    // One clock of stimulus; predicts acceptance at the coming edge.
    task automatic tick(input logic s, input logic [31:0] v, input logic r = 1'b0);
        exp_t e;
        int   edge_n;
        @(negedge clk);
        start     = s;
        binary_in = v;
        rst       = r;
        edge_n    = cyc + 1;
        if (r) begin
            next_ok = edge_n + 1;
        end else if (s && edge_n >= next_ok) begin
            e.val    = to_bcd(v);
            e.edge_n = edge_n + 32;
            exp_q.push_back(e);
            next_ok  = edge_n + 33;
        end
    endtask

    task automatic idle(input int n, input logic [31:0] v = 32'h0);
        for (int i = 0; i < n; i++) tick(1'b0, v);
    endtask

    task automatic convert(input logic [31:0] v);
        tick(1'b1, v);
        idle(34);
    endtask

    initial begin
        logic [31:0] vals[6];
        logic [31:0] v;
        int          gap;

        vals[0] = 32'd0;
        vals[1] = 32'd9;
        vals[2] = 32'd10;
        vals[3] = 32'd9999999;
        vals[4] = 32'd10000000;
        vals[5] = 32'hFFFF_FFFF;

        tick(1'b0, 32'h0, 1'b1);
        tick(1'b0, 32'h0, 1'b1);
        idle(2);

        convert(32'd12345);
        idle(5);

        foreach (vals[i]) convert(vals[i]);

        // start held, then re-pulsed, with binary_in changed mid-run
        tick(1'b1, 32'd12345);
        for (int i = 0; i < 5; i++) tick(1'b1, 32'd555);
        idle(10, 32'd555);
        tick(1'b1, 32'd555);
        idle(20, 32'd555);
        convert(32'd555);

        // start at the edge that raises done is ignored, next edge is accepted
        tick(1'b1, 32'd4321);
        idle(31);
        tick(1'b1, 32'd98765);
        tick(1'b1, 32'd98765);
        idle(36);

        // reset during a conversion
        tick(1'b1, 32'd12345);
        idle(10);
        tick(1'b0, 32'h0, 1'b1);
        idle(2);
        convert(32'd42);

        for (int k = 0; k < 25; k++) begin
            v = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 99)) : $urandom();
            tick(1'b1, v);
            gap = $urandom_range(20, 40);
            for (int j = 0; j < gap; j++) tick($urandom_range(0, 7) == 0, $urandom());
        end

        idle(40);
        if (exp_q.size() != 0) chk("pending_at_end", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
